rot_arb: RTL and testbench
==========================

Name: rot_arb

Overview:
- Two-requester round-robin front end for the shared barrel rotator datapath (`rot`).
- Accepts rotate jobs (word + amount) on two valid/ready ports and grants at most one per cycle.
- Drives a single combinational `rot` instance and registers its result into a one-entry output buffer, tagged with the requester id.
- Lets two consumers share one log2_N-stage rotator instead of each instantiating their own.

Parameters:
- N, 16384: word width in bits; must be a power of two.
- log2_N, 14: rotation-amount width; equals log2(N).

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has a job
- req0_ready  output  1  requester 0 job accepted this cycle (valid && ready)
- req0_bits  input  [0:N-1]  requester 0 word; index 0 is MSB
- req0_k  input  [0:log2_N-1]  requester 0 rotate amount; k[0] is MSB (weight N/2)
- req1_valid, req1_ready, req1_bits, req1_k: same as requester 0, for requester 1
- out_valid  output  1  result register holds a valid result
- out_ready  input  1  consumer accepts the result
- out_bits  output  [0:N-1]  rotated word: out_bits[j] = bits[(j - K) mod N], K = unsigned value of k (right rotate)
- out_id  output  1  requester index that produced out_bits

Behaviour:
- Reset (synchronous, rst=1 sampled on clk):
  - out_valid=0, out_bits=0, out_id=0, last_grant=1, so requester 0 wins the first tie.
  - req0_ready and req1_ready are forced to 0 while rst=1.
- can_accept = !out_valid || out_ready (the output register is empty or draining this cycle).
- Grant (combinational):
  - Only if can_accept.
  - One requester valid: grant it.
  - Both valid: grant the requester != last_grant.
  - Neither valid: no grant.
- reqX_ready = can_accept && grant==X && !rst. Ready may depend on valid; requesters must not make valid depend on ready.
- Datapath:
  - The mux selects the granted requester's bits/k into one `rot` instance, parameterised N/log2_N.
  - The `rot` instance is purely combinational; there are no stage registers inside it.
- On an accepted job: out_bits <= rot result, out_id <= grant, out_valid <= 1, last_grant <= grant.
- Latency: exactly 1 cycle from the req handshake to out_valid=1.
- Throughput: 1 job per cycle when out_ready is held high.
- Draining:
  - out_ready && out_valid with no new grant → out_valid <= 0.
  - Drain and grant in the same cycle → the register reloads and out_valid stays 1.
- Backpressure: out_valid && !out_ready → no grant, both readies 0; out_bits and out_id hold stable.
- last_grant changes only on an accepted job. Idle cycles preserve fairness state.
- k = 0 passes the word unchanged. k = N-1 rotates right by N-1 (equivalent to left by 1). No wrap handling beyond mod N.
- Reset mid-operation: any held result is discarded (out_valid=0). A job offered in the reset cycle is not accepted.
- Requester inputs are sampled only at the handshake. Changing an unaccepted job while valid is allowed; the arbiter uses the current-cycle value.

Decomposition:
- Shared package:
  - Requester-id localparams REQ0=0, REQ1=1.
  - A function computing the reference right-rotate, for the bench scoreboard.
- Sub-module: the existing `rot` (N, log2_N), instantiated once.
- Grant logic stays inline. A separate rr_arb2 sub-module is optional, not required.

Test Plan (N=16, log2_N=4):
- Single job: req0 bits=16'h8001, k=4'd1, out_ready=1 → next cycle out_valid=1, out_bits=16'hC000, out_id=0.
- Both valid every cycle, out_ready=1:
  - Cycle 1: req0 bits=16'h00F0 k=4 wins.
  - Cycle 2: req1 bits=16'h1234 k=8 wins.
  - Outputs in order: 16'h000F/id0, 16'h3412/id1, then id alternates 0,1,0,1.
- Backpressure: out_ready=0 with a result held, req1 valid → req1_ready=0 and out_bits stable for 3 cycles. Raising out_ready → req1 is accepted in that same cycle and its result appears next cycle.
- Boundaries:
  - k=0, bits=16'hA5A5 → 16'hA5A5.
  - k=15, bits=16'h0001 → 16'h0002.
  - k=8, bits=16'hFF00 → 16'h00FF.
- Reset mid-stream: out_valid=1 and rst asserted for 1 cycle with req0 valid → out_valid=0, req0_ready=0 during reset. The next tie grants req0.
- Random soak: 1000 cycles of random valids, out_ready, bits and k → every out_bits matches the package rotate function. No job is lost or duplicated, and with both requesters always valid neither is starved for more than 1 grant.

Source files
------------

// File: rtl/rot_arb_pkg.sv
// Shared definitions for the two-requester rotator front end: requester ids and a
// behavioural right-rotate reference used to score results.
package rot_arb_pkg;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Width of the reference rotate; matches the small configuration used for checking.
    localparam int unsigned RefW = 16;

    // out[j] = x[(j - k) mod RefW], index 0 is the MSB.
    function automatic logic [0:RefW-1] rot_right(input logic [0:RefW-1] x,
                                                  input int unsigned k);
        logic [0:RefW-1] r;
        int unsigned     km;
        km = k % RefW;
        for (int unsigned j = 0; j < RefW; j++) begin
            r[j] = x[(j + RefW - km) % RefW];
        end
        return r;
    endfunction

endpackage

// File: rtl/rot.sv
// Combinational log2_N-stage barrel rotator: right-rotates din by k, index 0 is the MSB.
module rot #(
    parameter int unsigned N      = 16384,
    parameter int unsigned log2_N = 14
) (
    input  logic [0:N-1]      din,
    input  logic [0:log2_N-1] k,
    output logic [0:N-1]      dout
);

    logic [0:N-1] stg [0:log2_N];

    assign stg[0] = din;

    for (genvar s = 0; s < int'(log2_N); s++) begin : g_stage
        localparam int unsigned Sh = 1 << s;
        // k[log2_N-1-s] carries weight 2**s.
        assign stg[s+1] = k[log2_N-1-s] ? {stg[s][N-Sh:N-1], stg[s][0:N-Sh-1]} : stg[s];
    end

    assign dout = stg[log2_N];

endmodule

// File: rtl/rot_arb.sv
// Round-robin front end sharing one combinational rotator between two requesters,
// with a one-entry registered output tagged by requester id.
module rot_arb
    import rot_arb_pkg::*;
#(
    parameter int unsigned N      = 16384,
    parameter int unsigned log2_N = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [0:N-1]      req0_bits,
    input  logic [0:log2_N-1] req0_k,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [0:N-1]      req1_bits,
    input  logic [0:log2_N-1] req1_k,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:N-1]      out_bits,
    output logic              out_id
);

    logic              can_accept;
    logic              grant_valid;
    logic              grant;
    logic              last_grant;
    logic [0:N-1]      sel_bits;
    logic [0:log2_N-1] sel_k;
    logic [0:N-1]      rot_out;

    always_comb begin
        can_accept  = !out_valid || out_ready;
        grant_valid = can_accept && (req0_valid || req1_valid) && !rst;
        grant       = REQ0;
        if (req0_valid && req1_valid) begin
            grant = (last_grant == REQ0) ? REQ1 : REQ0;
        end else if (req1_valid) begin
            grant = REQ1;
        end
        req0_ready = grant_valid && (grant == REQ0);
        req1_ready = grant_valid && (grant == REQ1);
        sel_bits   = (grant == REQ1) ? req1_bits : req0_bits;
        sel_k      = (grant == REQ1) ? req1_k : req0_k;
    end

    rot #(
        .N      (N),
        .log2_N (log2_N)
    ) u_rot (
        .din  (sel_bits),
        .k    (sel_k),
        .dout (rot_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_bits   <= '0;
            out_id     <= REQ0;
            last_grant <= REQ1;
        end else if (grant_valid) begin
            out_valid  <= 1'b1;
            out_bits   <= rot_out;
            out_id     <= grant;
            last_grant <= grant;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rot_arb.sv
// Directed and scoreboarded checks of rot_arb at N=16.
module tb_rot_arb;
    import rot_arb_pkg::*;

    localparam int unsigned N  = 16;
    localparam int unsigned LN = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [0:N-1]  req0_bits, req1_bits, out_bits;
    logic [0:LN-1] req0_k, req1_k;
    logic          out_valid, out_ready, out_id;

    int total = 0;
    int bad   = 0;

    rot_arb #(
        .N      (N),
        .log2_N (LN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_bits  (req0_bits),
        .req0_k     (req0_k),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_bits  (req1_bits),
        .req1_k     (req1_k),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bits   (out_bits),
        .out_id     (out_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Soak scoreboard state
    logic         m_valid, m_last, m_id, ca, gv, g, have_prev, prev_g;
    logic [0:N-1] m_bits;
    int           dut_acc, dut_cons;

    initial begin
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; out_ready = 0;
        req0_bits = '0; req1_bits = '0; req0_k = '0; req1_k = '0;
        step();
        step();
        rst = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_bits", 32'(out_bits), 32'd0);
        check("rst_id", 32'(out_id), 32'd0);

        // Single job
        req0_valid = 1; req0_bits = 16'h8001; req0_k = 4'd1; out_ready = 1;
        #1;
        check("single_ready", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 0;
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_bits", 32'(out_bits), 32'hC000);
        check("single_id", 32'(out_id), 32'd0);

        // Both valid every cycle; first tie after reset goes to req0
        pulse_reset();
        req0_valid = 1; req0_bits = 16'h00F0; req0_k = 4'd4;
        req1_valid = 1; req1_bits = 16'h1234; req1_k = 4'd8;
        #1;
        check("tie_r0", 32'(req0_ready), 32'd1);
        check("tie_r1", 32'(req1_ready), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("alt_valid", 32'(out_valid), 32'd1);
            check("alt_id", 32'(out_id), 32'(i % 2));
            check("alt_bits", 32'(out_bits), (i % 2 == 0) ? 32'h000F : 32'h3412);
        end
        req0_valid = 0; req1_valid = 0;
        step();
        check("drain", 32'(out_valid), 32'd0);

        // k=0 boundary, then hold it under backpressure
        req0_valid = 1; req0_bits = 16'hA5A5; req0_k = 4'd0;
        step();
        req0_valid = 0;
        check("k0_bits", 32'(out_bits), 32'hA5A5);
        out_ready = 0;
        req1_valid = 1; req1_bits = 16'hFF00; req1_k = 4'd8;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", 32'(req1_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_bits", 32'(out_bits), 32'hA5A5);
            step();
        end
        out_ready = 1;
        #1;
        check("bp_release", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 0;
        check("k8_bits", 32'(out_bits), 32'h00FF);
        check("k8_id", 32'(out_id), 32'd1);

        req0_valid = 1; req0_bits = 16'h0001; req0_k = 4'd15;
        step();
        req0_valid = 0;
        check("k15_bits", 32'(out_bits), 32'h0002);
        check("k15_id", 32'(out_id), 32'd0);

        // Reset while holding a result with req0 offering a job
        out_ready = 0; req0_valid = 1; rst = 1;
        #1;
        check("rstmid_ready", 32'(req0_ready), 32'd0);
        step();
        rst = 0;
        check("rstmid_valid", 32'(out_valid), 32'd0);
        req1_valid = 1;
        #1;
        check("rstmid_tie_r0", 32'(req0_ready), 32'd1);
        check("rstmid_tie_r1", 32'(req1_ready), 32'd0);
        out_ready = 1;
        step();
        req0_valid = 0; req1_valid = 0;
        check("rstmid_id", 32'(out_id), 32'd0);
        check("rstmid_bits", 32'(out_bits), 32'h0002);
        step();

        // Random soak; last 200 cycles keep both requesters valid
        pulse_reset();
        m_valid = 0; m_last = 1; m_id = 0; m_bits = '0;
        dut_acc = 0; dut_cons = 0; have_prev = 0; prev_g = 0;
        for (int c = 0; c < 1200; c++) begin
            req0_valid = (c >= 1000) ? 1'b1 : 1'($urandom_range(0, 1));
            req1_valid = (c >= 1000) ? 1'b1 : 1'($urandom_range(0, 1));
            out_ready  = ($urandom_range(0, 3) != 0);
            req0_bits  = 16'($urandom); req0_k = 4'($urandom_range(0, 15));
            req1_bits  = 16'($urandom); req1_k = 4'($urandom_range(0, 15));
            #1;
            ca = !m_valid || out_ready;
            gv = ca && (req0_valid || req1_valid);
            g  = (req0_valid && req1_valid) ? !m_last : req1_valid;
            check("soak_r0", 32'(req0_ready), 32'(gv && !g));
            check("soak_r1", 32'(req1_ready), 32'(gv && g));
            dut_acc  += int'(req0_valid && req0_ready) + int'(req1_valid && req1_ready);
            dut_cons += int'(out_valid && out_ready);
            if (c >= 1000 && (req0_ready || req1_ready)) begin
                if (have_prev) check("no_starve", 32'(req1_ready), 32'(!prev_g));
                have_prev = 1;
                prev_g    = req1_ready;
            end
            if (gv) begin
                m_bits  = rot_right(g ? req1_bits : req0_bits, g ? int'(req1_k) : int'(req0_k));
                m_id    = g;
                m_valid = 1;
                m_last  = g;
            end else if (out_ready) begin
                m_valid = 0;
            end
            step();
            check("soak_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                check("soak_bits", 32'(out_bits), 32'(m_bits));
                check("soak_id", 32'(out_id), 32'(m_id));
            end
        end
        check("conserve", 32'(dut_acc), 32'(dut_cons + int'(out_valid)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
